// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller. Owns the fetch PC, keeps one
//               instruction-memory request outstanding, arbitrates redirects
//               (exception > jump > branch) and holds the fetched word
//               against decode back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] fetch_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus_4;
    logic [31:0] r_fetch_count;

    logic        w_redir;
    logic [31:0] w_redir_addr;
    logic [31:0] w_pc_plus_4;

    // Redirect arbitration: exception wins over jump, jump over branch;
    // targets are always word aligned.
    always_comb begin
        w_redir      = exc_valid | jmp_valid | br_taken;
        w_redir_addr = br_target;
        if (exc_valid) begin
            w_redir_addr = EXC_VECTOR;
        end else if (jmp_valid) begin
            w_redir_addr = jmp_target;
        end
        w_redir_addr[1:0] = 2'b00;
    end

    assign w_pc_plus_4  = r_fetch_pc + 32'd4;

    assign imem_req     = (r_state == S_REQ);
    assign imem_addr    = r_fetch_pc;
    assign if_valid     = r_if_valid;
    assign if_instr     = r_if_instr;
    assign if_pc        = r_if_pc;
    assign if_pc_plus_4 = r_if_pc_plus_4;
    assign fetch_count  = r_fetch_count;

    // Fetch sequencing: request, wait for response, hold for decode; a
    // redirect while a request is in flight turns its response into a drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_fetch_pc     <= RESET_PC;
            r_if_valid     <= 1'b0;
            r_if_instr     <= 32'd0;
            r_if_pc        <= 32'd0;
            r_if_pc_plus_4 <= 32'd0;
            r_fetch_count  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_redir_addr;
                        // An accepted request for the old PC becomes stale.
                        if (imem_ready) begin
                            r_state <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_redir_addr;
                        r_state    <= imem_rvalid ? S_REQ : S_DROP;
                    end else if (imem_rvalid) begin
                        r_if_valid     <= 1'b1;
                        r_if_instr     <= imem_rdata;
                        r_if_pc        <= r_fetch_pc;
                        r_if_pc_plus_4 <= w_pc_plus_4;
                        r_state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        // Flush the held word; no handoff is counted.
                        r_fetch_pc <= w_redir_addr;
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end else if (!stall_in) begin
                        r_fetch_pc    <= w_pc_plus_4;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_if_valid    <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_redir_addr;
                    end
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
